// File: rtl/chirp_capture_sequencer_if.sv
// Datapath-side signals between the pulse sequencer and the chirp DDS / ADC capture path.
interface chirp_capture_sequencer_if;
    logic chirp_init;
    logic chirp_enable;
    logic adc_enable;
    logic chirp_ready;
    logic chirp_done;
    logic fifo_almost_full;

    modport master (
        output chirp_init, chirp_enable, adc_enable,
        input  chirp_ready, chirp_done, fifo_almost_full
    );

    modport slave (
        input  chirp_init, chirp_enable, adc_enable,
        output chirp_ready, chirp_done, fifo_almost_full
    );
endinterface

// File: rtl/chirp_capture_sequencer.sv
// Pulse-train sequencer: arms and fires the chirp DDS, opens a delayed ADC window,
// and holds the pulse-repetition period; skips pulses while the ADC FIFO is near full.
module chirp_capture_sequencer #(
    parameter int CNT_W       = 32,
    parameter int PCNT_W      = 16,
    parameter int RDY_TIMEOUT = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              abort,
    input  logic [PCNT_W-1:0] cfg_num_pulses,
    input  logic [CNT_W-1:0]  cfg_prp,
    input  logic [CNT_W-1:0]  cfg_adc_delay,
    input  logic [CNT_W-1:0]  cfg_adc_len,
    chirp_capture_sequencer_if.master dp,
    output logic              busy,
    output logic              seq_done,
    output logic              err_timeout,
    output logic [PCNT_W-1:0] pulse_count,
    output logic [PCNT_W-1:0] skip_count
);
    localparam int TMO_W = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, ARM, WAIT_RDY, FIRE, RUN, GAP, DONE
    } state_t;

    state_t state, state_nx;

    logic [PCNT_W-1:0] num_q;
    logic [CNT_W-1:0]  prp_q, dly_q, len_q;
    logic [CNT_W-1:0]  p_q, d_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              chirp_act;

    logic init_o, ce_o, adc_o;
    logic go, fire_ok, skip, tmo_hit, tmo_ev;
    logic p_end, more, in_win, win_over, active;

    assign go       = (state == IDLE) && start && !abort;
    assign fire_ok  = (state == FIRE) && !dp.fifo_almost_full;
    assign skip     = (state == FIRE) && dp.fifo_almost_full;
    assign tmo_hit  = tmo_q == TMO_W'(RDY_TIMEOUT - 1);
    assign tmo_ev   = (state == WAIT_RDY) && !dp.chirp_ready
                    && tmo_hit && !abort;
    assign p_end    = p_q >= (prp_q - 1'b1);
    assign more     = (num_q == '0) || (pulse_count != num_q);
    assign active   = (state != IDLE) && (state != DONE);

    // D counts from the chirp_enable rise; the window is [delay, delay+len).
    assign in_win   = (len_q != '0) && (d_q >= dly_q)
                    && ((d_q - dly_q) < len_q);
    assign win_over = (len_q == '0)
                    || ((d_q >= dly_q) && ((d_q - dly_q) >= len_q));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        init_o   = 1'b0;
        ce_o     = 1'b0;
        adc_o    = 1'b0;
        seq_done = 1'b0;
        unique case (state)
            IDLE: if (go) state_nx = ARM;
            ARM: begin
                init_o   = 1'b1;
                state_nx = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (dp.chirp_ready) begin
                    state_nx = FIRE;
                end else if (tmo_hit) begin
                    seq_done = 1'b1;
                    state_nx = IDLE;
                end
            end
            FIRE: begin
                if (dp.fifo_almost_full) begin
                    state_nx = GAP;
                end else begin
                    ce_o     = 1'b1;
                    adc_o    = in_win;
                    state_nx = RUN;
                end
            end
            RUN: begin
                ce_o  = chirp_act;
                adc_o = in_win;
                if (!chirp_act && win_over) state_nx = GAP;
            end
            GAP: begin
                if (p_end) begin
                    if (more) begin
                        state_nx = ARM;
                    end else begin
                        seq_done = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            DONE: begin
                seq_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Abort reports through DONE so seq_done fires exactly once.
        if (abort && active) begin
            seq_done = 1'b0;
            state_nx = DONE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            num_q       <= '0;
            prp_q       <= '0;
            dly_q       <= '0;
            len_q       <= '0;
            p_q         <= '0;
            d_q         <= '0;
            tmo_q       <= '0;
            chirp_act   <= 1'b0;
            err_timeout <= 1'b0;
            pulse_count <= '0;
            skip_count  <= '0;
        end else begin
            if (go) begin
                num_q       <= cfg_num_pulses;
                prp_q       <= cfg_prp;
                dly_q       <= cfg_adc_delay;
                len_q       <= cfg_adc_len;
                err_timeout <= 1'b0;
                pulse_count <= '0;
                skip_count  <= '0;
            end
            if (state_nx == ARM)
                p_q <= '0;
            else if (state != IDLE && p_q != '1)
                p_q <= p_q + 1'b1;
            if (state == ARM)
                tmo_q <= '0;
            else if (state == WAIT_RDY)
                tmo_q <= tmo_q + 1'b1;
            if (state == ARM)
                d_q <= '0;
            else if ((state == FIRE || state == RUN) && d_q != '1)
                d_q <= d_q + 1'b1;
            if (fire_ok)
                chirp_act <= 1'b1;
            else if (state == RUN && dp.chirp_done)
                chirp_act <= 1'b0;
            if (state_nx == DONE || state_nx == IDLE)
                chirp_act <= 1'b0;
            if (fire_ok && pulse_count != '1)
                pulse_count <= pulse_count + 1'b1;
            if (skip && skip_count != '1)
                skip_count <= skip_count + 1'b1;
            if (tmo_ev)
                err_timeout <= 1'b1;
        end
    end

    assign busy            = state != IDLE;
    assign dp.chirp_init   = init_o;
    assign dp.chirp_enable = ce_o;
    assign dp.adc_enable   = adc_o;
endmodule

// File: tb/tb_chirp_capture_sequencer.sv
// Directed bench for chirp_capture_sequencer: single pulse, train, backpressure,
// timeout, abort and async reset, with a cycle-level DDS responder.
module tb_chirp_capture_sequencer;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] cfg_num_pulses;
    logic [31:0] cfg_prp;
    logic [31:0] cfg_adc_delay;
    logic [31:0] cfg_adc_len;
    logic        busy;
    logic        seq_done;
    logic        err_timeout;
    logic [15:0] pulse_count;
    logic [15:0] skip_count;

    chirp_capture_sequencer_if dp ();

    chirp_capture_sequencer #(
        .CNT_W(32), .PCNT_W(16), .RDY_TIMEOUT(1024)
    ) dut (
        .aclk(clk),
        .aresetn(rst_n),
        .start(start),
        .abort(abort),
        .cfg_num_pulses(cfg_num_pulses),
        .cfg_prp(cfg_prp),
        .cfg_adc_delay(cfg_adc_delay),
        .cfg_adc_len(cfg_adc_len),
        .dp(dp),
        .busy(busy),
        .seq_done(seq_done),
        .err_timeout(err_timeout),
        .pulse_count(pulse_count),
        .skip_count(skip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rise_k = -1;
    int sweep = 40;
    int dly = 0;
    int len = 0;
    int bp_slot = 0;
    int exp_gap = 0;
    int n_init, n_done, adc_hi, adc_err, ce_err, gap_err;
    int first_init, last_init, done_cyc;
    bit chk_on = 1'b1;
    logic ce_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_init = 0; n_done = 0; adc_hi = 0; adc_err = 0;
        ce_err = 0; gap_err = 0; first_init = -1;
        last_init = -1; done_cyc = -1; rise_k = -1;
    endtask

    task automatic setcfg(input int num, input int prp,
                          input int d, input int l, input int sw);
        cfg_num_pulses = 16'(num);
        cfg_prp        = 32'(prp);
        cfg_adc_delay  = 32'(d);
        cfg_adc_len    = 32'(l);
        dly = d; len = l; sweep = sw; exp_gap = prp;
    endtask

    // One clock: drive the DDS response, then observe and score outputs.
    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
        if (rise_k >= 0) rise_k++;
        dp.chirp_done = (rise_k == sweep);
        #1;
        if (dp.chirp_init) begin
            if (last_init >= 0 && cyc - last_init != exp_gap) gap_err++;
            if (first_init < 0) first_init = cyc;
            last_init = cyc;
            n_init++;
            rise_k = -1;
        end
        if (dp.chirp_enable && !ce_prev) rise_k = 0;
        ce_prev = dp.chirp_enable;
        if (seq_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (dp.adc_enable) adc_hi++;
        if (chk_on) begin
            if (dp.adc_enable !== (rise_k >= dly && rise_k < dly + len))
                adc_err++;
            if (dp.chirp_enable !== (rise_k >= 0 && rise_k <= sweep))
                ce_err++;
        end
        dp.fifo_almost_full = (bp_slot != 0 && n_init == bp_slot);
    endtask

    task automatic run_seq(input string tag, input int budget);
        int d0;
        int i;
        d0 = n_done;
        i = 0;
        while (n_done == d0 && i < budget) begin
            step();
            i++;
        end
        chk(tag, 32'(n_done - d0), 32'd1);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        dp.chirp_ready = 1'b1;
        dp.chirp_done = 1'b0;
        dp.fifo_almost_full = 1'b0;
        setcfg(1, 100, 5, 20, 40);
        clr();
        repeat (3) @(posedge clk);
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {29'd0, dp.chirp_init, dp.chirp_enable,
                         dp.adc_enable}, 32'd0);
        chk("rst_cnt", {pulse_count, skip_count}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single pulse, with a start during WAIT_RDY that must be ignored
        clr();
        start = 1'b1; step(); start = 1'b0;
        chk("t1_arm_init", {31'd0, dp.chirp_init}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        step(); start = 1'b1; step(); start = 1'b0;
        run_seq("t1_end", 300);
        chk("t1_inits", n_init, 1);
        chk("t1_done_p", done_cyc - first_init, 99);
        chk("t1_adc_hi", adc_hi, 20);
        chk("t1_adc_err", adc_err, 0);
        chk("t1_ce_err", ce_err, 0);
        chk("t1_pulses", pulse_count, 1);
        chk("t1_skips", skip_count, 0);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // Pulse train
        clr();
        setcfg(3, 64, 3, 10, 20);
        start = 1'b1; step(); start = 1'b0;
        run_seq("t2_end", 400);
        chk("t2_inits", n_init, 3);
        chk("t2_gap_err", gap_err, 0);
        chk("t2_dones", n_done, 1);
        chk("t2_pulses", pulse_count, 3);
        chk("t2_adc_hi", adc_hi, 30);
        chk("t2_adc_err", adc_err, 0);

        // Backpressure on pulse slot 2
        clr();
        bp_slot = 2;
        start = 1'b1; step(); start = 1'b0;
        run_seq("t3_end", 500);
        bp_slot = 0;
        dp.fifo_almost_full = 1'b0;
        chk("t3_inits", n_init, 4);
        chk("t3_skips", skip_count, 1);
        chk("t3_pulses", pulse_count, 3);
        chk("t3_adc_hi", adc_hi, 30);
        chk("t3_adc_err", adc_err, 0);
        chk("t3_gap_err", gap_err, 0);

        // Ready timeout, then a new start clears the error
        clr();
        setcfg(1, 100, 5, 20, 40);
        dp.chirp_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        run_seq("t4_end", 2000);
        chk("t4_tmo_cyc", done_cyc - first_init, 1024);
        chk("t4_err", {31'd0, err_timeout}, 32'd1);
        chk("t4_idle", {31'd0, busy}, 32'd0);
        chk("t4_pulses", pulse_count, 0);
        dp.chirp_ready = 1'b1;
        clr();
        start = 1'b1; step(); start = 1'b0;
        chk("t4_err_clr", {31'd0, err_timeout}, 32'd0);
        run_seq("t4_rerun", 300);
        chk("t4_rerun_pulses", pulse_count, 1);

        // Abort in the middle of the capture window
        clr();
        setcfg(0, 100, 5, 20, 40);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 50 && rise_k != 10; i++) step();
        chk("t5_reach", rise_k, 10);
        chk("t5_adc_on", {31'd0, dp.adc_enable}, 32'd1);
        abort = 1'b1;
        chk_on = 1'b0;
        step();
        abort = 1'b0;
        chk("t5_ce_off", {31'd0, dp.chirp_enable}, 32'd0);
        chk("t5_adc_off", {31'd0, dp.adc_enable}, 32'd0);
        chk("t5_done", {31'd0, seq_done}, 32'd1);
        step();
        chk("t5_done_1cyc", {31'd0, seq_done}, 32'd0);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        chk("t5_pulses_held", pulse_count, 1);
        chk("t5_dones", n_done, 1);

        // start and abort together from IDLE: no sequence
        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        step();
        chk("t6_held", pulse_count, 1);

        // Async reset during RUN, then a clean sequence
        clr();
        setcfg(1, 100, 5, 20, 40);
        chk_on = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 20 && rise_k != 3; i++) step();
        chk("t7_reach", rise_k, 3);
        rst_n = 1'b0;
        #1;
        chk("t7_ce", {31'd0, dp.chirp_enable}, 32'd0);
        chk("t7_busy", {31'd0, busy}, 32'd0);
        chk("t7_cnt", {16'd0, pulse_count}, 32'd0);
        chk_on = 1'b0;
        step(); step();
        rst_n = 1'b1;
        clr();
        chk_on = 1'b1;
        step();
        start = 1'b1; step(); start = 1'b0;
        run_seq("t7_end", 300);
        chk("t7_inits", n_init, 1);
        chk("t7_done_p", done_cyc - first_init, 99);
        chk("t7_adc_hi", adc_hi, 20);
        chk("t7_adc_err", adc_err, 0);
        chk("t7_pulses", pulse_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
